// File: rtl/ex_operand_stage.sv
// ID/EX operand stage: forwards rs/rt from EX/MEM/WB into the ALU operand registers,
// requests a one-cycle stall on load-use and handles flush/freeze bubbles.
module ex_operand_stage #(
  parameter int         DATA_W     = 16,
  parameter logic [3:0] NOP_OPCODE = 4'b1111
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_use_imm,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [3:0]        id_opcode,
  input  logic [3:0]        id_rs,
  input  logic [3:0]        id_rt,
  input  logic [3:0]        id_rd,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] mem_result,
  input  logic [DATA_W-1:0] wb_result,
  input  logic [3:0]        mem_rd,
  input  logic [3:0]        wb_rd,
  input  logic              mem_reg_write,
  input  logic              wb_reg_write,
  input  logic              flush,
  input  logic              freeze,
  output logic [3:0]        ex_opcode,
  output logic [DATA_W-1:0] ex_input1,
  output logic [DATA_W-1:0] ex_input2,
  output logic [3:0]        ex_rd,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              stall_out
);

  logic              vld_p1;
  logic              reg_write_p1;
  logic              mem_read_p1;
  logic              mem_write_p1;
  logic [3:0]        opcode_p1;
  logic [3:0]        rd_p1;
  logic [DATA_W-1:0] input1_p1;
  logic [DATA_W-1:0] input2_p1;

  logic              load_use;
  logic [DATA_W-1:0] rs_fwd;
  logic [DATA_W-1:0] rt_fwd;

  // A load in EX has no result yet, so it is excluded from EX forwarding and stalls instead.
  function automatic logic [DATA_W-1:0] fwd_sel(
    input logic [3:0]        src,
    input logic [DATA_W-1:0] rf_data,
    input logic              ex_hit_ok,
    input logic [3:0]        ex_dst,
    input logic [DATA_W-1:0] ex_data,
    input logic              mem_we,
    input logic [3:0]        mem_dst,
    input logic [DATA_W-1:0] mem_data,
    input logic              wb_we,
    input logic [3:0]        wb_dst,
    input logic [DATA_W-1:0] wb_data
  );
    logic [DATA_W-1:0] sel;
    sel = rf_data;
    if (src != 4'd0) begin
      if (ex_hit_ok && ex_dst == src)       sel = ex_data;
      else if (mem_we && mem_dst == src)    sel = mem_data;
      else if (wb_we && wb_dst == src)      sel = wb_data;
    end
    return sel;
  endfunction

  // ID side: forwarding muxes and hazard detection against the instruction held in EX
  always_comb begin
    rs_fwd = fwd_sel(id_rs, id_rs_data, vld_p1 & reg_write_p1 & ~mem_read_p1, rd_p1,
                     alu_result, mem_reg_write, mem_rd, mem_result,
                     wb_reg_write, wb_rd, wb_result);
    rt_fwd = fwd_sel(id_rt, id_rt_data, vld_p1 & reg_write_p1 & ~mem_read_p1, rd_p1,
                     alu_result, mem_reg_write, mem_rd, mem_result,
                     wb_reg_write, wb_rd, wb_result);
    load_use = vld_p1 & mem_read_p1 & (rd_p1 != 4'd0) & id_valid &
               ((id_uses_rs & (id_rs == rd_p1)) | (id_uses_rt & (id_rt == rd_p1)));
  end

  assign stall_out = load_use & ~flush;

  // ID -> EX register boundary
  always_ff @(posedge clk) begin
    if (rst || flush || (!freeze && (load_use || !id_valid))) begin
      vld_p1       <= 1'b0;
      reg_write_p1 <= 1'b0;
      mem_read_p1  <= 1'b0;
      mem_write_p1 <= 1'b0;
      opcode_p1    <= NOP_OPCODE;
      rd_p1        <= 4'd0;
      input1_p1    <= '0;
      input2_p1    <= '0;
    end else if (!freeze) begin
      vld_p1       <= 1'b1;
      reg_write_p1 <= id_reg_write;
      mem_read_p1  <= id_mem_read;
      mem_write_p1 <= id_mem_write;
      opcode_p1    <= id_opcode;
      rd_p1        <= id_rd;
      input1_p1    <= rs_fwd;
      input2_p1    <= id_use_imm ? id_imm : rt_fwd;
    end
  end

  assign ex_valid     = vld_p1;
  assign ex_reg_write = reg_write_p1;
  assign ex_mem_read  = mem_read_p1;
  assign ex_mem_write = mem_write_p1;
  assign ex_opcode    = opcode_p1;
  assign ex_rd        = rd_p1;
  assign ex_input1    = input1_p1;
  assign ex_input2    = input2_p1;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: stimulus pushes hand-computed EX state and stall
// expectations into a queue; a negedge monitor pops and compares.
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst, flush, freeze;
  logic        id_valid, id_reg_write, id_mem_read, id_mem_write, id_use_imm, id_uses_rs, id_uses_rt;
  logic [3:0]  id_opcode, id_rs, id_rt, id_rd;
  logic [15:0] id_rs_data, id_rt_data, id_imm;
  logic [15:0] alu_result, mem_result, wb_result;
  logic [3:0]  mem_rd, wb_rd;
  logic        mem_reg_write, wb_reg_write;
  logic [3:0]  ex_opcode, ex_rd;
  logic [15:0] ex_input1, ex_input2;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, stall_out;

  ex_operand_stage #(.DATA_W(16), .NOP_OPCODE(4'b1111)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_use_imm(id_use_imm), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .alu_result(alu_result), .mem_result(mem_result), .wb_result(wb_result),
    .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
    .flush(flush), .freeze(freeze),
    .ex_opcode(ex_opcode), .ex_input1(ex_input1), .ex_input2(ex_input2), .ex_rd(ex_rd),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .stall_out(stall_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        v, rw, mr, mw;
    logic [3:0]  rd, op;
    logic [15:0] in1, in2;
    logic        stall;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;
  int   pop_no = 0;

  function automatic exp_t S(input logic [3:0] op, rd, input logic rw, mr, mw,
                             input logic [15:0] in1, in2, input logic stall);
    exp_t e;
    e.v = 1'b1; e.rw = rw; e.mr = mr; e.mw = mw; e.rd = rd; e.op = op;
    e.in1 = in1; e.in2 = in2; e.stall = stall;
    return e;
  endfunction

  function automatic exp_t B(input logic stall);
    exp_t e;
    e.v = 1'b0; e.rw = 1'b0; e.mr = 1'b0; e.mw = 1'b0; e.rd = 4'd0; e.op = 4'hF;
    e.in1 = 16'h0; e.in2 = 16'h0; e.stall = stall;
    return e;
  endfunction

  task automatic set_id(input logic v, input logic [3:0] op, rs, rt, rd,
                        input logic rw, mr, mw, imm_sel, urs, urt,
                        input logic [15:0] rsd, rtd, imm);
    id_valid = v; id_opcode = op; id_rs = rs; id_rt = rt; id_rd = rd;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = mw; id_use_imm = imm_sel;
    id_uses_rs = urs; id_uses_rt = urt; id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
  endtask

  task automatic set_dn(input logic [15:0] alu, mem, wb, input logic [3:0] mrd, wrd,
                        input logic mrw, wrw);
    alu_result = alu; mem_result = mem; wb_result = wb;
    mem_rd = mrd; wb_rd = wrd; mem_reg_write = mrw; wb_reg_write = wrw;
  endtask

  // e describes the EX state held now and stall_out for the inputs just applied
  task automatic step(input exp_t e);
    sb.push_back(e);
    step_no++;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      exp_t got;
      e = sb.pop_front();
      pop_no++;
      got = {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_rd, ex_opcode,
             ex_input1, ex_input2, stall_out};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL step%0d v/rw/mr/mw=%b%b%b%b rd=%h op=%h in1=%h in2=%h stall=%b ; expected v/rw/mr/mw=%b%b%b%b rd=%h op=%h in1=%h in2=%h stall=%b",
                 pop_no, got.v, got.rw, got.mr, got.mw, got.rd, got.op, got.in1, got.in2, got.stall,
                 e.v, e.rw, e.mr, e.mw, e.rd, e.op, e.in1, e.in2, e.stall);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t add_s, lw_s;
    rst = 1'b1; flush = 1'b0; freeze = 1'b0;
    set_dn(16'h0, 16'h0, 16'h0, 4'd0, 4'd0, 1'b0, 1'b0);
    set_id(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // plain capture after reset
    set_id(1, 4'd0, 4'd1, 4'd2, 4'd3, 1, 0, 0, 0, 1, 1, 16'h0001, 16'h0002, 16'h0);
    step(B(0));
    // priority: EX > MEM > WB, all targeting r3
    set_dn(16'h0005, 16'h0009, 16'h000A, 4'd3, 4'd3, 1, 1);
    set_id(1, 4'd1, 4'd3, 4'd0, 4'd5, 1, 0, 0, 0, 1, 1, 16'h0077, 16'h0022, 16'h0);
    step(S(4'd0, 4'd3, 1, 0, 0, 16'h0001, 16'h0002, 0));
    set_id(1, 4'd2, 4'd0, 4'd0, 4'd3, 0, 0, 0, 0, 1, 1, 16'h0000, 16'h0000, 16'h0);
    step(S(4'd1, 4'd5, 1, 0, 0, 16'h0005, 16'h0022, 0));
    set_id(1, 4'd1, 4'd3, 4'd0, 4'd5, 1, 0, 0, 0, 1, 1, 16'h0077, 16'h0022, 16'h0);
    step(S(4'd2, 4'd3, 0, 0, 0, 16'h0000, 16'h0000, 0));
    set_dn(16'h0005, 16'h0009, 16'h000A, 4'd3, 4'd3, 0, 1);
    step(S(4'd1, 4'd5, 1, 0, 0, 16'h0009, 16'h0022, 0));
    // register 0 never forwards
    set_dn(16'h0005, 16'h0009, 16'h000A, 4'd0, 4'd0, 1, 1);
    set_id(1, 4'd0, 4'd1, 4'd2, 4'd0, 1, 0, 0, 0, 1, 1, 16'h0011, 16'h0033, 16'h0);
    step(S(4'd1, 4'd5, 1, 0, 0, 16'h000A, 16'h0022, 0));
    set_dn(16'h5555, 16'h0009, 16'h000A, 4'd0, 4'd0, 1, 1);
    set_id(1, 4'd3, 4'd0, 4'd0, 4'd6, 1, 0, 0, 0, 1, 1, 16'h0000, 16'h0000, 16'h0);
    step(S(4'd0, 4'd0, 1, 0, 0, 16'h0011, 16'h0033, 0));
    // immediate overrides an active rt forward, then rt forward alone
    set_dn(16'h4444, 16'h0000, 16'h0000, 4'd0, 4'd0, 0, 0);
    set_id(1, 4'd4, 4'd1, 4'd6, 4'd7, 1, 0, 0, 1, 1, 1, 16'h0010, 16'h0099, 16'hFFF8);
    step(S(4'd3, 4'd6, 1, 0, 0, 16'h0000, 16'h0000, 0));
    set_id(1, 4'd5, 4'd1, 4'd7, 4'd8, 1, 0, 0, 0, 1, 1, 16'h0010, 16'h0099, 16'hFFF8);
    step(S(4'd4, 4'd7, 1, 0, 0, 16'h0010, 16'hFFF8, 0));
    // load-use: one bubble, then MEM forwarding
    set_id(1, 4'd6, 4'd1, 4'd0, 4'd4, 1, 1, 0, 1, 1, 0, 16'h0100, 16'h0000, 16'h0004);
    step(S(4'd5, 4'd8, 1, 0, 0, 16'h0010, 16'h4444, 0));
    lw_s = S(4'd6, 4'd4, 1, 1, 0, 16'h0100, 16'h0004, 0);
    set_id(1, 4'd0, 4'd4, 4'd2, 4'd9, 1, 0, 0, 0, 1, 1, 16'hDEAD, 16'h0002, 16'h0);
    lw_s.stall = 1'b1;
    step(lw_s);
    set_dn(16'h4444, 16'h1234, 16'h0000, 4'd4, 4'd0, 1, 0);
    step(B(0));
    // freeze holds for three cycles
    add_s = S(4'd0, 4'd9, 1, 0, 0, 16'h1234, 16'h0002, 0);
    set_id(1, 4'd7, 4'd1, 4'd2, 4'd10, 1, 0, 0, 0, 1, 1, 16'h0055, 16'h0066, 16'h0);
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) step(add_s);
    freeze = 1'b0;
    set_dn(16'h4444, 16'h0000, 16'h0000, 4'd0, 4'd0, 0, 0);
    set_id(1, 4'd6, 4'd1, 4'd0, 4'd4, 1, 1, 0, 1, 1, 0, 16'h0100, 16'h0000, 16'h0004);
    step(add_s);
    // load-use under freeze still stalls and holds; flush wins and masks the stall
    set_id(1, 4'd0, 4'd4, 4'd2, 4'd9, 1, 0, 0, 0, 1, 1, 16'hDEAD, 16'h0002, 16'h0);
    freeze = 1'b1;
    lw_s.stall = 1'b1;
    step(lw_s);
    flush = 1'b1;
    lw_s.stall = 1'b0;
    step(lw_s);
    flush = 1'b0; freeze = 1'b0;
    set_id(1, 4'd2, 4'd1, 4'd2, 4'd11, 1, 0, 0, 0, 0, 0, 16'h0021, 16'h0031, 16'h0);
    step(B(0));
    // id_valid=0 is captured as a bubble
    set_id(0, 4'd3, 4'd1, 4'd2, 4'd12, 1, 1, 1, 0, 1, 1, 16'h0021, 16'h0031, 16'h0);
    step(S(4'd2, 4'd11, 1, 0, 0, 16'h0021, 16'h0031, 0));
    set_id(1, 4'd1, 4'd1, 4'd2, 4'd13, 1, 0, 1, 0, 1, 1, 16'h0041, 16'h0042, 16'h0);
    step(B(0));
    // mid-stream reset wins over freeze
    rst = 1'b1; freeze = 1'b1;
    step(S(4'd1, 4'd13, 1, 0, 1, 16'h0041, 16'h0042, 0));
    rst = 1'b0; freeze = 1'b0;
    set_id(1, 4'd0, 4'd4, 4'd2, 4'd9, 1, 0, 0, 0, 1, 1, 16'h0007, 16'h0002, 16'h0);
    step(B(0));
    step(S(4'd0, 4'd9, 1, 0, 0, 16'h0007, 16'h0002, 0));

    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain queue_left=%0d required=0", sb.size());
    end
    checks++;
    if (pop_no != step_no) begin
      errors++;
      $display("FAIL monitor_count popped=%0d required=%0d", pop_no, step_no);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_operand_stage.md
EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

Interface
REQ-001 SHALL have parameter DATA_W, 16, datapath width.
REQ-002 SHALL have parameter NOP_OPCODE, 4'b1111, opcode driven for bubbles; opcode[3]=1 so the ALU does not update flags.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports id_valid, id_reg_write, id_mem_read, id_mem_write, id_use_imm, id_uses_rs, id_uses_rt  input  1 each  decode-stage control.
REQ-006 SHALL have ports id_opcode, id_rs, id_rt, id_rd  input  4 each  decode opcode and register fields.
REQ-007 SHALL have ports id_rs_data, id_rt_data, id_imm  input  DATA_W each  register file reads and extended immediate.
REQ-008 SHALL have ports alu_result, mem_result, wb_result  input  DATA_W each  ALU output of the EX instruction, MEM-stage result (load data if load), WB write data.
REQ-009 SHALL have ports mem_rd, wb_rd  input  4 each, and mem_reg_write, wb_reg_write  input  1 each  downstream destinations.
REQ-010 SHALL have ports flush, freeze  input  1 each  kill the instruction entering EX; hold all EX state.
REQ-011 SHALL have ports ex_opcode  output  4; ex_input1, ex_input2  output  DATA_W; ex_rd  output  4  registered ALU operands and destination.
REQ-012 SHALL have ports ex_valid, ex_reg_write, ex_mem_read, ex_mem_write  output  1 each  registered control.
REQ-013 SHALL have port stall_out  output  1  combinational load-use stall request to fetch/decode.

Function
REQ-014 SHALL forward each source operand (rs, rt) at capture time with priority: EX (ex_valid & ex_reg_write & ~ex_mem_read & ex_rd==src -> alu_result) > MEM (mem_reg_write & mem_rd==src -> mem_result) > WB (wb_reg_write & wb_rd==src -> wb_result) > register file data.
REQ-015 SHALL never forward register 0; src==0 always selects the register file value.
REQ-016 SHALL set ex_input1 = forwarded rs, ex_input2 = id_use_imm ? id_imm : forwarded rt.
REQ-017 SHALL detect load-use: ex_valid & ex_mem_read & ex_rd!=0 & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)) & id_valid.
REQ-018 SHALL drive stall_out = load_use & ~flush; combinational, independent of freeze.
REQ-019 SHALL, per clock, apply the first matching case: rst -> reset values; flush -> bubble; freeze -> hold all registers; load_use -> bubble; otherwise capture decode fields.
REQ-020 SHALL define bubble as ex_valid=0, ex_reg_write=0, ex_mem_read=0, ex_mem_write=0, ex_rd=0, ex_opcode=NOP_OPCODE, ex_input1=ex_input2=0.
REQ-021 SHALL capture id_valid=0 as a bubble (controls zeroed, ex_opcode=NOP_OPCODE).
REQ-022 SHALL insert exactly one bubble per load-use hazard; the next cycle the load is in MEM and forwards via mem_result.
REQ-023 SHALL apply no arithmetic; all operand paths are DATA_W-bit muxes with no truncation.

Reset
REQ-024 SHALL, on rst at a clock edge, load bubble values on all registered outputs regardless of flush/freeze.
REQ-025 SHALL, with ex_valid=0 after reset, hold stall_out=0 until a load is captured.

Verification
REQ-026 SHALL cover reset: rst=1 one edge mid-stream with ex_valid=1 -> ex_valid=0, ex_opcode=4'b1111, ex_input1=ex_input2=0, stall_out=0.
REQ-027 SHALL cover priority: EX holds ADD rd=3 with alu_result=16'h0005, mem_rd=3 mem_result=16'h0009, wb_rd=3 wb_result=16'h000A; ID SUB rs=3 -> ex_input1=16'h0005 next edge; repeat with ex_reg_write=0 -> 16'h0009; mem_reg_write=0 -> 16'h000A.
REQ-028 SHALL cover register 0: rs=0, id_rs_data=0, all forward sources target rd=0 with nonzero data -> ex_input1=0.
REQ-029 SHALL cover load-use: EX holds LW rd=4; ID ADD rs=4 -> stall_out=1, next edge bubble; next cycle mem_rd=4 mem_result=16'h1234 -> ADD captured with ex_input1=16'h1234, stall_out=0.
REQ-030 SHALL cover flush/freeze: freeze=1 three cycles -> outputs unchanged; flush=1 with freeze=1 and load-use present -> bubble, stall_out=0.
REQ-031 SHALL cover immediate: id_use_imm=1, id_imm=16'hFFF8, rt forwarding active -> ex_input2=16'hFFF8.
